// File: rtl/collision_pkg.sv
// Shared definitions for the collision subsystem: scheduler state encoding,
// default sprite ranges and the collision codes used by the flag updater.
package collision_pkg;

  // Default sprite layout: mobiles occupy the low indices, fixed sprites follow.
  localparam int DEFAULT_BITS_TO_SPRITE      = 5;
  localparam int DEFAULT_BEGIN_MOBILE_SPRITE = 0;
  localparam int DEFAULT_END_MOBILE_SPRITE   = 14;
  localparam int DEFAULT_END_FIXED_SPRITE    = 31;
  localparam int DEFAULT_TIMEOUT_CYCLES      = 15;

  // Scheduler states, one pass walks SEEK/WAIT/UPDATE until the pairs run out.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEEK   = 3'd1,
    WAIT   = 3'd2,
    UPDATE = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } sched_state_t;

  // Per-sprite collision codes kept by the flag updater.
  typedef enum logic [1:0] {
    COLLIDE_NONE   = 2'b00,
    COLLIDE_MOBILE = 2'b01,
    COLLIDE_FIXED  = 2'b10,
    COLLIDE_BOTH   = 2'b11
  } collision_code_t;

endpackage

// File: rtl/pair_index_counter.sv
// Nested (mobile, comparison) index counters for one collision pass.
// The mobile counter carries one extra bit so that stepping past the last
// mobile sprite is visible as pass_done instead of wrapping to zero.
module pair_index_counter #(
  parameter int bits_to_sprite      = 5,
  parameter int begin_mobile_sprite = 0,
  parameter int end_mobile_sprite   = 14,
  parameter int end_fixed_sprite    = 31
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic                      advance,
  input  logic [end_fixed_sprite:0] sprite_active,
  output logic [bits_to_sprite-1:0] mobile,
  output logic [bits_to_sprite-1:0] comparison,
  output logic                      pair_ok,
  output logic                      pass_done
);

  localparam logic [bits_to_sprite:0]   M_FIRST = (bits_to_sprite + 1)'(begin_mobile_sprite);
  localparam logic [bits_to_sprite:0]   M_LAST  = (bits_to_sprite + 1)'(end_mobile_sprite);
  localparam logic [bits_to_sprite-1:0] C_LAST  = bits_to_sprite'(end_fixed_sprite);

  logic [bits_to_sprite:0]   m_q;
  logic [bits_to_sprite-1:0] c_q;
  logic [bits_to_sprite-1:0] m_idx;

  // Step through candidates mobile-major, comparison ascending.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; reset is synchronous, so it is an ordinary priority branch.
    if (reset) begin
      m_q <= '0;
      c_q <= '0;
    end else if (init) begin
      m_q <= M_FIRST;
      c_q <= '0;
    end else if (advance) begin
      if (c_q == C_LAST) begin
        c_q <= '0;
        m_q <= m_q + 1'b1;
      end else begin
        c_q <= c_q + 1'b1;
      end
    end
  end

  assign m_idx      = m_q[bits_to_sprite-1:0];
  assign mobile     = m_idx;
  assign comparison = c_q;
  assign pass_done  = (m_q > M_LAST);

  // A candidate is a real pair when both sprites are live and distinct.
  assign pair_ok = !pass_done
                && sprite_active[m_idx]
                && sprite_active[c_q]
                && (m_idx != c_q);

endmodule

// File: rtl/collision_scheduler.sv
// Collision-analysis sequencer: on start, walks every live (mobile,
// comparison) pair, hands each one to the overlap checker, forwards the
// result to the flag updater and finally strobes the commit.
module collision_scheduler
  import collision_pkg::*;
#(
  parameter int bits_to_sprite      = DEFAULT_BITS_TO_SPRITE,
  parameter int begin_mobile_sprite = DEFAULT_BEGIN_MOBILE_SPRITE,
  parameter int end_mobile_sprite   = DEFAULT_END_MOBILE_SPRITE,
  parameter int end_fixed_sprite    = DEFAULT_END_FIXED_SPRITE,
  parameter int timeout_cycles      = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [end_fixed_sprite:0] sprite_active,
  input  logic                      result_valid,
  input  logic                      checker_collision,
  output logic                      pair_valid,
  output logic [bits_to_sprite-1:0] number_of_mobile_sprite,
  output logic [bits_to_sprite-1:0] number_of_comparison_sprite,
  output logic                      enable,
  output logic                      collision_result,
  output logic                      process_finished,
  output logic                      busy,
  output logic                      timeout_error
);

  localparam int               TW        = $clog2(timeout_cycles + 1);
  localparam logic [TW-1:0]    WAIT_LAST = TW'(timeout_cycles - 1);

  sched_state_t  state, state_next;
  logic [TW-1:0] wait_cnt;
  logic          init_pass;
  logic          advance_pair;
  logic          pair_ok;
  logic          pass_done;
  logic          timed_out;

  pair_index_counter #(
    .bits_to_sprite      (bits_to_sprite),
    .begin_mobile_sprite (begin_mobile_sprite),
    .end_mobile_sprite   (end_mobile_sprite),
    .end_fixed_sprite    (end_fixed_sprite)
  ) u_pair_index_counter (
    .clk           (clk),
    .reset         (reset),
    .init          (init_pass),
    .advance       (advance_pair),
    .sprite_active (sprite_active),
    .mobile        (number_of_mobile_sprite),
    .comparison    (number_of_comparison_sprite),
    .pair_ok       (pair_ok),
    .pass_done     (pass_done)
  );

  // The last permitted WAIT cycle with no answer abandons the pair.
  assign timed_out = (state == WAIT) && !result_valid && (wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: defaulting every combinational output before the case keeps
    // unlisted paths from inferring latches.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SEEK;
      SEEK: begin
        if (pass_done)    state_next = COMMIT;
        else if (pair_ok) state_next = WAIT;
      end
      WAIT:    if (result_valid || timed_out) state_next = UPDATE;
      UPDATE:  state_next = SEEK;
      COMMIT:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs and counter controls decoded from the current state.
  always_comb begin
    pair_valid       = 1'b0;
    enable           = 1'b0;
    process_finished = 1'b1;
    busy             = 1'b0;
    init_pass        = 1'b0;
    advance_pair     = 1'b0;
    case (state)
      IDLE: init_pass = start;
      SEEK: begin
        busy         = 1'b1;
        advance_pair = !pass_done && !pair_ok;
      end
      WAIT: begin
        busy       = 1'b1;
        pair_valid = 1'b1;
      end
      UPDATE: begin
        busy         = 1'b1;
        enable       = 1'b1;
        advance_pair = 1'b1;
      end
      COMMIT: begin
        busy             = 1'b1;
        process_finished = 1'b0;
      end
      default: ;
    endcase
  end

  // WAIT-cycle counter, cleared whenever the FSM is outside WAIT.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  // Result latch: checker answer, or a forced no-collision on abandon.
  always_ff @(posedge clk) begin
    if (reset) begin
      collision_result <= 1'b0;
    end else if (state == WAIT) begin
      if (result_valid)   collision_result <= checker_collision;
      else if (timed_out) collision_result <= 1'b0;
    end
  end

  // Sticky abandon flag, cleared when a new pass is accepted.
  always_ff @(posedge clk) begin
    if (reset)                        timeout_error <= 1'b0;
    else if (state == IDLE && start)  timeout_error <= 1'b0;
    else if (timed_out)               timeout_error <= 1'b1;
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Self-checking bench for collision_scheduler: a checker model with random
// latency and results drives the handshake, while the expected pair list,
// results and commit timing come from a queue built from the sprite mask.
module tb_collision_scheduler;

  localparam int N_MOBILE = 15;
  localparam int N_SPRITE = 32;
  localparam int TIMEOUT  = 15;
  localparam int BUDGET   = 6000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] act;
  logic        result_valid;
  logic        checker_collision;
  logic        pair_valid;
  logic [4:0]  number_of_mobile_sprite;
  logic [4:0]  number_of_comparison_sprite;
  logic        enable;
  logic        collision_result;
  logic        process_finished;
  logic        busy;
  logic        timeout_error;

  int   checks = 0;
  int   errors = 0;
  logic prev_to = 1'b0;

  collision_scheduler dut (
    .clk                         (clk),
    .reset                       (reset),
    .start                       (start),
    .sprite_active               (act),
    .result_valid                (result_valid),
    .checker_collision           (checker_collision),
    .pair_valid                  (pair_valid),
    .number_of_mobile_sprite     (number_of_mobile_sprite),
    .number_of_comparison_sprite (number_of_comparison_sprite),
    .enable                      (enable),
    .collision_result            (collision_result),
    .process_finished            (process_finished),
    .busy                        (busy),
    .timeout_error               (timeout_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pair_valid"}, pair_valid, 0);
    check({tag, "_enable"}, enable, 0);
    check({tag, "_coll"}, collision_result, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_to"}, timeout_error, 0);
    check({tag, "_pf"}, process_finished, 1);
    check({tag, "_m"}, number_of_mobile_sprite, 0);
    check({tag, "_c"}, number_of_comparison_sprite, 0);
  endtask

  // lat_mode: 0 = checker never answers, >0 fixed latency, <0 random 1..4.
  // coll_mode: 0 all clear, 1 all overlap, 2 random.
  // abort_n: pulse reset during the WAIT of the n-th pair (<0 = never).
  task automatic run_pass(input logic [31:0] pattern, input int lat_mode,
                          input int coll_mode, input bit noise, input int abort_n);
    int   q_m[$];
    int   q_c[$];
    int   k, n_en, fin, fin_k, lat_sum, wc, lat, pairs_seen, exp_pairs;
    logic cur_coll, cur_exp;
    logic exp_to;
    bit   done_ok;

    for (int m = 0; m < N_MOBILE; m++)
      for (int c = 0; c < N_SPRITE; c++)
        if (pattern[m] && pattern[c] && c != m) begin
          q_m.push_back(m);
          q_c.push_back(c);
        end
    exp_pairs  = q_m.size();
    exp_to     = (lat_mode == 0) && (exp_pairs > 0);
    n_en = 0; fin = 0; fin_k = 0; lat_sum = 0; wc = 0; lat = 0; pairs_seen = 0;
    cur_coll = 1'b0; cur_exp = 1'b0; done_ok = 1'b0;

    act = pattern;
    check("to_sticky_idle", timeout_error, prev_to);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    check("to_cleared", timeout_error, 0);
    check("busy_start", busy, 1);

    while (k < BUDGET) begin
      if (enable) begin
        n_en++;
        if (q_m.size() == 0) begin
          check("extra_enable", 1, 0);
        end else begin
          check("pair_m", number_of_mobile_sprite, q_m.pop_front());
          check("pair_c", number_of_comparison_sprite, q_c.pop_front());
          check("coll", collision_result, cur_exp);
        end
      end
      if (!process_finished) begin
        fin++;
        fin_k = k;
      end
      if (!busy) begin
        done_ok = 1'b1;
        break;
      end

      start = noise && ($urandom_range(0, 15) == 0);
      if (pair_valid) begin
        if (wc == 0) begin
          pairs_seen++;
          if (pairs_seen == abort_n) begin
            start        = 1'b0;
            result_valid = 1'b0;
            reset        = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_reset_outputs("abort");
            repeat (4) begin
              @(negedge clk);
              check("abort_no_commit", process_finished, 1);
              check("abort_idle", busy, 0);
            end
            prev_to = 1'b0;
            return;
          end
          lat      = (lat_mode < 0) ? int'($urandom_range(1, 4)) : lat_mode;
          cur_coll = (coll_mode == 2) ? logic'($urandom_range(0, 1)) : coll_mode[0];
          cur_exp  = (lat > 0) ? cur_coll : 1'b0;
          lat_sum += ((lat > 0) ? lat : TIMEOUT) + 1;
        end
        wc++;
        result_valid      = (lat > 0) && (wc >= lat);
        checker_collision = cur_coll;
      end else begin
        wc                = 0;
        result_valid      = noise && ($urandom_range(0, 3) == 0);
        checker_collision = logic'($urandom_range(0, 1));
      end
      @(negedge clk);
      k++;
    end

    start        = 1'b0;
    result_valid = 1'b0;
    if (!done_ok) check("pass_budget", 0, 1);
    check("enable_count", n_en, exp_pairs);
    check("pairs_left", q_m.size(), 0);
    check("commit_count", fin, 1);
    // Every candidate costs one SEEK cycle, plus a final SEEK that sees the
    // range exhausted; each live pair adds its WAIT cycles and one UPDATE.
    check("commit_cycle", fin_k, N_MOBILE * N_SPRITE + 2 + lat_sum);
    check("timeout_err", timeout_error, exp_to);
    @(negedge clk);
    check("idle_pf", process_finished, 1);
    check("idle_busy", busy, 0);
    prev_to = exp_to;
  endtask

  initial begin
    clk               = 1'b0;
    reset             = 1'b1;
    start             = 1'b0;
    act               = '0;
    result_valid      = 1'b0;
    checker_collision = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    run_pass(32'hFFFF_FFFF, 1, 0, 1'b0, -1);   // every pair, fast checker
    run_pass(32'h0010_0001, 1, 1, 1'b0, -1);   // single pair (0,20), overlap
    run_pass(32'h0000_0006, 0, 2, 1'b0, -1);   // silent checker, two timeouts
    run_pass(32'hFFFF_FFFF, -1, 2, 1'b1, -1);  // random latency plus noise
    repeat (2) run_pass($urandom, -1, 2, 1'b1, -1);
    run_pass(32'hFFFF_FFFF, 2, 1, 1'b0, 2);    // reset inside second WAIT
    run_pass(32'hFFFF_FFFF, -1, 2, 1'b0, -1);  // full pass after the abort
    run_pass(32'h0000_0000, 1, 0, 1'b1, -1);   // nothing active

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
